// File: rtl/alu_seq_param.sv
// Multi-cycle WIDTH-generic ALU: single-cycle add/sub, iterative shift-add
// multiply and restoring divide, with a held result and status flags.
module alu_seq_param #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         opcode,
    input  logic [WIDTH-1:0]   port_a,
    input  logic [WIDTH-1:0]   port_b,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               neg,
    output logic               div_zero
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state, state_nx;

    logic             is_mul;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    // Multiplier bits (mul) or dividend-in / quotient-out bits (div)
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] b_r;

    logic             accept;
    logic             zero_div;
    logic             iter_op;
    logic             last_iter;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [RW-1:0]    acc_nx;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   sh_sub;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] q_nx;

    assign accept    = start && (state != EXEC);
    assign zero_div  = (opcode == OP_DIV) && (port_b == '0);
    assign iter_op   = opcode[1] && !zero_div;
    assign last_iter = (cnt == CNT_LAST);

    assign sum  = {1'b0, port_a} + {1'b0, port_b};
    assign diff = {1'b0, port_a} - {1'b0, port_b};

    assign acc_nx = mq[0] ? (acc + mcand) : acc;

    assign sh     = {rem, mq[WIDTH-1]};
    assign sh_sub = sh - {1'b0, b_r};
    assign ge     = (sh >= {1'b0, b_r});
    assign rem_nx = ge ? sh_sub[WIDTH-1:0] : sh[WIDTH-1:0];
    assign q_nx   = {mq[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx = iter_op ? EXEC : DONE;
                end else begin
                    state_nx = IDLE;
                end
            end
            EXEC: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EXEC);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_mul   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mq       <= '0;
            rem      <= '0;
            b_r      <= '0;
            result   <= '0;
            neg      <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            is_mul <= !opcode[0];
            cnt    <= CNT_INIT;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, port_a};
            mq     <= opcode[0] ? port_a : port_b;
            rem    <= '0;
            b_r    <= port_b;
            if (!iter_op) begin
                case (opcode)
                    OP_ADD: begin
                        result   <= {{(WIDTH-1){1'b0}}, sum};
                        neg      <= 1'b0;
                        div_zero <= 1'b0;
                    end
                    OP_SUB: begin
                        result   <= {{(WIDTH-1){diff[WIDTH]}}, diff};
                        neg      <= diff[WIDTH];
                        div_zero <= 1'b0;
                    end
                    default: begin
                        result   <= {port_a, {WIDTH{1'b1}}};
                        neg      <= 1'b0;
                        div_zero <= 1'b1;
                    end
                endcase
            end
        end else if (state == EXEC) begin
            cnt <= cnt - CNT_LAST;
            if (is_mul) begin
                acc   <= acc_nx;
                mcand <= mcand << 1;
                mq    <= mq >> 1;
            end else begin
                rem <= rem_nx;
                mq  <= q_nx;
            end
            if (last_iter) begin
                result   <= is_mul ? acc_nx : {rem_nx, q_nx};
                neg      <= 1'b0;
                div_zero <= 1'b0;
            end
        end
    end

endmodule
